// File: rtl/asmi_reply_tx.sv
// Reply transmitter for the EPCS flash programming stage. Watches the erase_done and
// send_more level flags, wins the Tx path, streams one fixed-format reply payload and
// then holds the matching ACK until the flash stage withdraws its flag.
module asmi_reply_tx #(
  parameter int unsigned REPLY_LEN  = 60,
  parameter logic [7:0]  CODE_ERASE = 8'h03,
  parameter logic [7:0]  CODE_MORE  = 8'h04
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        erase_done,
  input  logic        send_more,
  output logic        erase_done_ACK,
  output logic        send_more_ACK,
  input  logic [47:0] mac,
  output logic        tx_request,
  input  logic        tx_grant,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last
);

  typedef enum logic [1:0] {StIdle, StReq, StSend, StAck} state_e;

  localparam logic [7:0] LastIdx = 8'(REPLY_LEN - 1);

  state_e     state_q, state_d;
  logic       erase_sync_q, more_sync_q;
  logic       sel_erase_q, sel_erase_d;   // 1: serving erase_done, 0: serving send_more
  logic [7:0] idx_q, idx_d;
  logic [7:0] seq_q, seq_d;
  logic [7:0] code;
  logic [7:0] frame_byte;
  logic       at_last;

  assign code    = sel_erase_q ? CODE_ERASE : CODE_MORE;
  assign at_last = (idx_q == LastIdx);

  // Flags change on the source's negedge; one posedge register brings them into our domain.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      erase_sync_q <= 1'b0;
      more_sync_q  <= 1'b0;
    end else begin
      erase_sync_q <= erase_done;
      more_sync_q  <= send_more;
    end
  end

  // State, selection, byte index and sequence number registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sel_erase_q <= 1'b0;
      idx_q       <= 8'd0;
      seq_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      sel_erase_q <= sel_erase_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
    end
  end

  // Next-state and Moore outputs; erase_done takes priority when both flags are up.
  always_comb begin
    state_d        = state_q;
    sel_erase_d    = sel_erase_q;
    idx_d          = idx_q;
    seq_d          = seq_q;
    tx_request     = 1'b0;
    tx_valid       = 1'b0;
    erase_done_ACK = 1'b0;
    send_more_ACK  = 1'b0;
    case (state_q)
      StIdle: begin
        if (erase_sync_q) begin
          sel_erase_d = 1'b1;
          state_d     = StReq;
        end else if (more_sync_q) begin
          sel_erase_d = 1'b0;
          state_d     = StReq;
        end
      end
      StReq: begin
        tx_request = 1'b1;
        if (tx_grant) begin
          idx_d   = 8'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        // Grant is no longer looked at: the slot is ours until the last byte goes out.
        tx_request = 1'b1;
        tx_valid   = 1'b1;
        if (tx_ready) begin
          if (at_last) begin
            seq_d   = seq_q + 8'd1;
            state_d = StAck;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StAck: begin
        if (sel_erase_q) begin
          erase_done_ACK = 1'b1;
          if (!erase_sync_q) state_d = StIdle;
        end else begin
          send_more_ACK = 1'b1;
          if (!more_sync_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Payload byte selected by index: magic, code, MAC (MSB first), sequence, zero padding.
  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      8'd0:    frame_byte = 8'hEF;
      8'd1:    frame_byte = 8'hFE;
      8'd2:    frame_byte = 8'h03;
      8'd3:    frame_byte = code;
      8'd4:    frame_byte = mac[47:40];
      8'd5:    frame_byte = mac[39:32];
      8'd6:    frame_byte = mac[31:24];
      8'd7:    frame_byte = mac[23:16];
      8'd8:    frame_byte = mac[15:8];
      8'd9:    frame_byte = mac[7:0];
      8'd10:   frame_byte = seq_q;
      default: frame_byte = 8'h00;
    endcase
  end

  assign tx_data = tx_valid ? frame_byte : 8'h00;
  assign tx_last = (state_q == StSend) && at_last;

endmodule

// File: tb/tb_asmi_reply_tx.sv
// Self-checking bench for asmi_reply_tx: table of handshake scenarios, hand-written reset
// and sequence-wrap sequences, and randomized handshakes against a frame-level model.
module tb_asmi_reply_tx;

  localparam int unsigned RLEN = 60;
  localparam logic [7:0]  CE   = 8'h03;
  localparam logic [7:0]  CM   = 8'h04;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        erase_done, send_more;
  logic        erase_done_ACK, send_more_ACK;
  logic [47:0] mac;
  logic        tx_request, tx_grant;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_last;

  asmi_reply_tx #(.REPLY_LEN(RLEN), .CODE_ERASE(CE), .CODE_MORE(CM)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .erase_done     (erase_done),
    .send_more      (send_more),
    .erase_done_ACK (erase_done_ACK),
    .send_more_ACK  (send_more_ACK),
    .mac            (mac),
    .tx_request     (tx_request),
    .tx_grant       (tx_grant),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_last        (tx_last)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Monitor state (written at negedge, read by the driver after posedge).
  logic [7:0] got[$];
  bit         frame_done;
  int         last_cnt, last_pos;
  int         overlap_cnt = 0;
  int         stall_viol = 0;
  bit         stall_pend = 0;
  logic [7:0] stall_data;
  logic       stall_last;

  // Model state: sequence number the next frame must carry.
  logic [7:0] model_seq;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] ref_byte(int i, logic [7:0] code, logic [7:0] seq,
                                          logic [47:0] m);
    if (i == 0) return 8'hEF;
    if (i == 1) return 8'hFE;
    if (i == 2) return 8'h03;
    if (i == 3) return code;
    if (i >= 4 && i <= 9) return 8'(m >> (8 * (9 - i)));
    if (i == 10) return seq;
    return 8'h00;
  endfunction

  function automatic logic ready_bit(int mode, int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Accepted bytes are those with valid && ready at the negedge preceding the active edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      stall_pend = 0;
    end else begin
      if (erase_done_ACK && send_more_ACK) overlap_cnt++;
      if (stall_pend && tx_valid && (tx_data !== stall_data || tx_last !== stall_last))
        stall_viol++;
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
      stall_last = tx_last;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (tx_last) begin
          last_cnt++;
          last_pos   = got.size() - 1;
          frame_done = 1;
        end
      end
    end
  end

  // One full handshake: raise flag (optionally), wait for request, grant, stream, ACK, drop.
  task automatic serve(input bit is_erase, input bit set_flag, input int exp_lat,
                       input int grant_dly, input int rmode, input int hold,
                       input logic [7:0] exp_code);
    int n;
    bit ok;
    int bad;
    frame_done = 0;
    last_cnt   = 0;
    last_pos   = -1;
    got.delete();
    if (set_flag) begin
      if (is_erase) erase_done = 1'b1;
      else send_more = 1'b1;
    end
    n = 0;
    while (!tx_request && n < 20) begin
      tick();
      n++;
    end
    check(tx_request == 1'b1, "req_timeout", tx_request, 1);
    if (exp_lat >= 0) check(n == exp_lat, "req_latency", n, exp_lat);
    repeat (grant_dly) begin
      tick();
    end
    tx_grant = 1'b1;
    n = 0;
    while (!frame_done && n < 3000) begin
      tx_ready = ready_bit(rmode, n);
      tick();
      tx_grant = 1'b0;
      n++;
    end
    tx_ready = 1'b0;
    tx_grant = 1'b0;
    check(frame_done, "frame_timeout", frame_done, 1);
    check(got.size() == RLEN, "accept_count", got.size(), RLEN);
    bad = -1;
    for (int i = 0; i < got.size() && i < RLEN; i++)
      if (bad < 0 && got[i] !== ref_byte(i, exp_code, model_seq, mac)) bad = i;
    if (bad >= 0)
      check(0, $sformatf("frame_byte[%0d]", bad), got[bad],
            ref_byte(bad, exp_code, model_seq, mac));
    else
      check(1, "frame_bytes", 0, 0);
    check(last_cnt == 1 && last_pos == RLEN - 1, "tx_last_pos", last_pos, RLEN - 1);
    model_seq = model_seq + 8'd1;
    check({tx_valid, tx_request, tx_last} == 3'b000, "post_frame_idle",
          {tx_valid, tx_request, tx_last}, 0);
    check({erase_done_ACK, send_more_ACK} == (is_erase ? 2'b10 : 2'b01), "ack_on",
          {erase_done_ACK, send_more_ACK}, is_erase ? 2 : 1);
    ok = 1;
    repeat (hold) begin
      tick();
      if ({erase_done_ACK, send_more_ACK} != (is_erase ? 2'b10 : 2'b01) || tx_request ||
          tx_valid) ok = 0;
    end
    if (hold > 0) check(ok, "ack_hold", ok, 1);
    if (is_erase) erase_done = 1'b0;
    else send_more = 1'b0;
    tick();
    check({erase_done_ACK, send_more_ACK} == (is_erase ? 2'b10 : 2'b01), "ack_after_drop",
          {erase_done_ACK, send_more_ACK}, is_erase ? 2 : 1);
    tick();
    check(is_erase ? !erase_done_ACK : !send_more_ACK, "ack_release",
          {erase_done_ACK, send_more_ACK}, 0);
  endtask

  typedef struct {
    bit          erase;
    bit          more;
    int          grant_dly;
    int          rmode;
    int          hold;
    logic [47:0] mac;
    logic [7:0]  exp_code1;
    logic [7:0]  exp_code2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [47:0] outs;
    int n;
    bit is_e;

    vecs[0] = '{1, 0, 3, 0, 0,  48'h0012345678AB, 8'h03, 8'h00};
    vecs[1] = '{0, 1, 0, 1, 0,  48'h0012345678AB, 8'h04, 8'h00};
    vecs[2] = '{1, 1, 1, 0, 2,  48'hA1B2C3D4E5F6, 8'h03, 8'h04};
    vecs[3] = '{0, 1, 2, 0, 50, 48'hFFEEDDCCBBAA, 8'h04, 8'h00};
    vecs[4] = '{1, 0, 0, 1, 3,  48'h010203040506, 8'h03, 8'h00};

    reset_n = 1'b0; erase_done = 1'b0; send_more = 1'b0;
    tx_grant = 1'b0; tx_ready = 1'b0; mac = 48'h0;
    model_seq = 8'd0;
    tick();
    tick();
    outs = {40'h0, tx_request, tx_valid, tx_last, erase_done_ACK, send_more_ACK} |
           {40'h0, tx_data};
    check(outs == 0, "reset_state", outs, 0);
    reset_n = 1'b1;
    tick();

    // Table-driven scenarios.
    for (int v = 0; v < 5; v++) begin
      mac = vecs[v].mac;
      if (vecs[v].erase && vecs[v].more) begin
        erase_done = 1'b1;
        send_more  = 1'b1;
        serve(1, 0, 2, vecs[v].grant_dly, vecs[v].rmode, vecs[v].hold, vecs[v].exp_code1);
        check(send_more_ACK == 1'b0, "no_early_more_ack", send_more_ACK, 0);
        serve(0, 0, 1, vecs[v].grant_dly, vecs[v].rmode, 0, vecs[v].exp_code2);
      end else begin
        serve(vecs[v].erase, 1, 2, vecs[v].grant_dly, vecs[v].rmode, vecs[v].hold,
              vecs[v].exp_code1);
      end
      tick();
    end

    // Reset in the middle of a send_more frame with the flag still raised.
    mac = 48'h0012345678AB;
    send_more = 1'b1;
    got.delete();
    n = 0;
    while (!tx_request && n < 20) begin tick(); n++; end
    tx_grant = 1'b1;
    tx_ready = 1'b1;
    n = 0;
    while (got.size() < 20 && n < 200) begin tick(); tx_grant = 1'b0; n++; end
    check(got.size() == 20, "reach_byte20", got.size(), 20);
    reset_n = 1'b0;
    tick();
    outs = {40'h0, tx_request, tx_valid, tx_last, erase_done_ACK, send_more_ACK} |
           {40'h0, tx_data};
    check(outs == 0, "midframe_reset_outputs", outs, 0);
    tx_ready = 1'b0;
    reset_n = 1'b1;
    model_seq = 8'd0;
    serve(0, 0, 2, 1, 0, 0, CM);
    tick();

    // Back-to-back send_more handshakes wrap the sequence byte.
    for (int f = 0; f < 257; f++) serve(0, 1, 2, 0, 0, 0, CM);
    check(model_seq == 8'd2, "seq_wrap_model", model_seq, 2);
    tick();

    // Randomized handshakes with random MAC, grant delay, ready pattern and hold time.
    for (int r = 0; r < 20; r++) begin
      mac  = {$urandom(), 16'($urandom())};
      is_e = 1'($urandom_range(0, 1));
      serve(is_e, 1, 2, $urandom_range(0, 4), 2, $urandom_range(0, 5), is_e ? CE : CM);
      repeat ($urandom_range(0, 3)) tick();
    end

    check(overlap_cnt == 0, "ack_overlap", overlap_cnt, 0);
    check(stall_viol == 0, "stall_stability", stall_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
